// File: rtl/excp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : excp_pkg
// Purpose  : Shared types and constants for the precise-exception sequencer.
//            Provides the sequencer state encoding and the CSR.ESTAT Ecode
//            values that the commit path produces or tests against.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package excp_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } excp_state_e;

    // CSR.ESTAT Ecode values (6-bit architectural field)
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // An instruction retiring in WB triggers a commit if it carries an
    // exception, is an ERTN, or an interrupt is pending at that moment.
    function automatic logic is_commit_event(input logic valid,
                                             input logic intr,
                                             input logic excp,
                                             input logic ertn);
        return valid & (intr | excp | ertn);
    endfunction

endpackage
`default_nettype wire

// File: rtl/excp_cause_sel.sv
`default_nettype none
// ============================================================================
// Module   : excp_cause_sel
// Purpose  : Combinational priority selection of the commit cause from the
//            WB-stage instruction. Priority: interrupt > exception > ERTN.
//            An ERTN that also carries an exception is handled as exception.
// Ports    : int_req/wb_excp/wb_ertn      - cause sources
//            wb_ecode/wb_esubcode/wb_pc   - exception fields from WB
//            wb_badv/wb_badv_vld          - faulting address and its qualifier
//            csr_eentry/csr_era_in        - redirect targets from the CSR file
//            sel_excp/sel_ertn            - selected commit kind (one-hot or 0)
//            sel_ecode/sel_esubcode/sel_era/sel_badv_we/sel_badv - CSR fields
//            sel_target                   - PC redirect target
// Revision : 1.0 - initial release
// ============================================================================
module excp_cause_sel
    import excp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ECODE_W = 6,
    parameter int ESUB_W  = 9
) (
    input  logic                int_req,
    input  logic                wb_excp,
    input  logic                wb_ertn,
    input  logic [ECODE_W-1:0]  wb_ecode,
    input  logic [ESUB_W-1:0]   wb_esubcode,
    input  logic [ADDR_W-1:0]   wb_pc,
    input  logic [ADDR_W-1:0]   wb_badv,
    input  logic                wb_badv_vld,
    input  logic [ADDR_W-1:0]   csr_eentry,
    input  logic [ADDR_W-1:0]   csr_era_in,
    output logic                sel_excp,
    output logic                sel_ertn,
    output logic [ECODE_W-1:0]  sel_ecode,
    output logic [ESUB_W-1:0]   sel_esubcode,
    output logic [ADDR_W-1:0]   sel_era,
    output logic                sel_badv_we,
    output logic [ADDR_W-1:0]   sel_badv,
    output logic [ADDR_W-1:0]   sel_target
);

    always_comb begin
        sel_excp     = 1'b0;
        sel_ertn     = 1'b0;
        sel_ecode    = '0;
        sel_esubcode = '0;
        sel_era      = wb_pc;
        sel_badv_we  = 1'b0;
        sel_badv     = wb_badv;
        sel_target   = csr_eentry;

        if (int_req) begin
            // Interrupt is taken on this instruction boundary; ERA is the
            // retiring PC so the instruction re-executes after ERTN.
            sel_excp  = 1'b1;
            sel_ecode = ECODE_W'(ECODE_INT);
        end else if (wb_excp) begin
            sel_excp     = 1'b1;
            sel_ecode    = wb_ecode;
            sel_esubcode = wb_esubcode;
            sel_badv_we  = wb_badv_vld;
        end else if (wb_ertn) begin
            sel_ertn   = 1'b1;
            sel_target = csr_era_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/excp_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : excp_commit_ctrl
// Purpose  : Precise-exception sequencer for the 5-stage pipeline. Raises a
//            global flush when any stage reports an exception, waits for the
//            excepting instruction to retire in WB, commits the exception or
//            ERTN to the CSR file, kills the pipeline and hands a PC redirect
//            to IF via a valid/ready handshake.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            if/id/ex/me_excp           - upstream exception flags
//            wb_*                       - retiring instruction information
//            int_req                    - pending enabled interrupt
//            csr_eentry, csr_era_in     - exception entry / ERTN target
//            global_flush               - flush/stall flag to all stages
//            flush_all                  - one-cycle pipeline kill
//            csr_excp_we, csr_ecode, csr_esubcode, csr_era,
//            csr_badv_we, csr_badv      - CSR exception write
//            ertn_commit                - one-cycle PLV/IE restore pulse
//            redirect_valid/_pc/_ready  - PC redirect handshake with IF
//            perf_excp_cnt, perf_ertn_cnt - commit counters (optional)
// Options  : EXCP_PERF_CNT_EN - when defined, adds the two 32-bit wrapping
//            commit counters and their output ports.
// Revision : 1.0 - initial release
// ============================================================================
module excp_commit_ctrl
    import excp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ECODE_W = 6,
    parameter int ESUB_W  = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_excp,
    input  logic                id_excp,
    input  logic                ex_excp,
    input  logic                me_excp,
    input  logic                wb_valid,
    input  logic                wb_excp,
    input  logic                wb_ertn,
    input  logic [ECODE_W-1:0]  wb_ecode,
    input  logic [ESUB_W-1:0]   wb_esubcode,
    input  logic [ADDR_W-1:0]   wb_pc,
    input  logic [ADDR_W-1:0]   wb_badv,
    input  logic                wb_badv_vld,
    input  logic                int_req,
    input  logic [ADDR_W-1:0]   csr_eentry,
    input  logic [ADDR_W-1:0]   csr_era_in,
    output logic                global_flush,
    output logic                flush_all,
    output logic                csr_excp_we,
    output logic [ECODE_W-1:0]  csr_ecode,
    output logic [ESUB_W-1:0]   csr_esubcode,
    output logic [ADDR_W-1:0]   csr_era,
    output logic                csr_badv_we,
    output logic [ADDR_W-1:0]   csr_badv,
    output logic                ertn_commit,
    output logic                redirect_valid,
    output logic [ADDR_W-1:0]   redirect_pc,
`ifdef EXCP_PERF_CNT_EN
    output logic [31:0]         perf_excp_cnt,
    output logic [31:0]         perf_ertn_cnt,
`endif
    input  logic                redirect_ready
);

    excp_state_e          state;
    excp_state_e          state_nxt;

    logic                 sel_excp;
    logic                 sel_ertn;
    logic [ECODE_W-1:0]   sel_ecode;
    logic [ESUB_W-1:0]    sel_esubcode;
    logic [ADDR_W-1:0]    sel_era;
    logic                 sel_badv_we;
    logic [ADDR_W-1:0]    sel_badv;
    logic [ADDR_W-1:0]    sel_target;

    logic                 commit_ev;
    logic                 upstream_excp;
    logic                 take_commit;

    logic                 global_flush_nxt;
    logic                 flush_all_nxt;
    logic                 csr_excp_we_nxt;
    logic                 csr_badv_we_nxt;
    logic                 ertn_commit_nxt;
    logic                 redirect_valid_nxt;

    excp_cause_sel #(
        .ADDR_W  (ADDR_W),
        .ECODE_W (ECODE_W),
        .ESUB_W  (ESUB_W)
    ) u_cause_sel (
        .int_req      (int_req),
        .wb_excp      (wb_excp),
        .wb_ertn      (wb_ertn),
        .wb_ecode     (wb_ecode),
        .wb_esubcode  (wb_esubcode),
        .wb_pc        (wb_pc),
        .wb_badv      (wb_badv),
        .wb_badv_vld  (wb_badv_vld),
        .csr_eentry   (csr_eentry),
        .csr_era_in   (csr_era_in),
        .sel_excp     (sel_excp),
        .sel_ertn     (sel_ertn),
        .sel_ecode    (sel_ecode),
        .sel_esubcode (sel_esubcode),
        .sel_era      (sel_era),
        .sel_badv_we  (sel_badv_we),
        .sel_badv     (sel_badv),
        .sel_target   (sel_target)
    );

    assign commit_ev     = is_commit_event(wb_valid, int_req, wb_excp, wb_ertn);
    assign upstream_excp = if_excp | id_excp | ex_excp | me_excp;

    // ------------------------------------------------------------------
    // Next-state and next-output logic. All outputs are registered, so
    // this block computes the values they take after the coming edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt          = state;
        take_commit        = 1'b0;
        global_flush_nxt   = global_flush;
        flush_all_nxt      = 1'b0;
        csr_excp_we_nxt    = 1'b0;
        csr_badv_we_nxt    = 1'b0;
        ertn_commit_nxt    = 1'b0;
        redirect_valid_nxt = redirect_valid;

        case (state)
            ST_IDLE: begin
                if (commit_ev) begin
                    take_commit = 1'b1;
                end else if (upstream_excp) begin
                    state_nxt        = ST_DRAIN;
                    global_flush_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Older, non-excepting instructions keep retiring here;
                // only a commit event moves the sequencer on.
                if (commit_ev) begin
                    take_commit = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_nxt          = ST_REDIRECT;
                redirect_valid_nxt = 1'b1;
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt          = ST_IDLE;
                    redirect_valid_nxt = 1'b0;
                    global_flush_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (take_commit) begin
            state_nxt        = ST_COMMIT;
            global_flush_nxt = 1'b1;
            flush_all_nxt    = 1'b1;
            csr_excp_we_nxt  = sel_excp;
            csr_badv_we_nxt  = sel_excp & sel_badv_we;
            ertn_commit_nxt  = sel_ertn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            global_flush   <= 1'b0;
            flush_all      <= 1'b0;
            csr_excp_we    <= 1'b0;
            csr_badv_we    <= 1'b0;
            ertn_commit    <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            global_flush   <= global_flush_nxt;
            flush_all      <= flush_all_nxt;
            csr_excp_we    <= csr_excp_we_nxt;
            csr_badv_we    <= csr_badv_we_nxt;
            ertn_commit    <= ertn_commit_nxt;
            redirect_valid <= redirect_valid_nxt;
        end
    end

    // Commit payload is captured at the same edge that enters COMMIT and
    // held until the next commit, so redirect_pc is stable throughout the
    // whole REDIRECT wait regardless of CSR activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_ecode    <= '0;
            csr_esubcode <= '0;
            csr_era      <= '0;
            csr_badv     <= '0;
            redirect_pc  <= '0;
        end else if (take_commit) begin
            csr_ecode    <= sel_ecode;
            csr_esubcode <= sel_esubcode;
            csr_era      <= sel_era;
            csr_badv     <= sel_badv;
            redirect_pc  <= sel_target;
        end
    end

`ifdef EXCP_PERF_CNT_EN
    // Counters step during the COMMIT pulse and wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_excp_cnt <= '0;
            perf_ertn_cnt <= '0;
        end else if (state == ST_COMMIT) begin
            if (csr_excp_we) begin
                perf_excp_cnt <= perf_excp_cnt + 32'd1;
            end
            if (ertn_commit) begin
                perf_ertn_cnt <= perf_ertn_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_excp_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_excp_commit_ctrl
// Purpose  : Self-checking bench for excp_commit_ctrl. Each WB commit event
//            driven pushes its expected CSR payload and redirect target to
//            scoreboard queues; a negedge monitor pops and compares them
//            when the DUT pulses its commit outputs / completes a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_excp_commit_ctrl;

    localparam int ADDR_W  = 32;
    localparam int ECODE_W = 6;
    localparam int ESUB_W  = 9;

    logic                clk = 1'b0;
    logic                reset;
    logic                if_excp, id_excp, ex_excp, me_excp;
    logic                wb_valid, wb_excp, wb_ertn;
    logic [ECODE_W-1:0]  wb_ecode;
    logic [ESUB_W-1:0]   wb_esubcode;
    logic [ADDR_W-1:0]   wb_pc, wb_badv;
    logic                wb_badv_vld;
    logic                int_req;
    logic [ADDR_W-1:0]   csr_eentry, csr_era_in;
    logic                global_flush, flush_all, csr_excp_we;
    logic [ECODE_W-1:0]  csr_ecode;
    logic [ESUB_W-1:0]   csr_esubcode;
    logic [ADDR_W-1:0]   csr_era;
    logic                csr_badv_we;
    logic [ADDR_W-1:0]   csr_badv;
    logic                ertn_commit;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                redirect_ready;
`ifdef EXCP_PERF_CNT_EN
    logic [31:0]         perf_excp_cnt, perf_ertn_cnt;
`endif

    excp_commit_ctrl #(
        .ADDR_W  (ADDR_W),
        .ECODE_W (ECODE_W),
        .ESUB_W  (ESUB_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_excp        (if_excp),
        .id_excp        (id_excp),
        .ex_excp        (ex_excp),
        .me_excp        (me_excp),
        .wb_valid       (wb_valid),
        .wb_excp        (wb_excp),
        .wb_ertn        (wb_ertn),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_pc          (wb_pc),
        .wb_badv        (wb_badv),
        .wb_badv_vld    (wb_badv_vld),
        .int_req        (int_req),
        .csr_eentry     (csr_eentry),
        .csr_era_in     (csr_era_in),
        .global_flush   (global_flush),
        .flush_all      (flush_all),
        .csr_excp_we    (csr_excp_we),
        .csr_ecode      (csr_ecode),
        .csr_esubcode   (csr_esubcode),
        .csr_era        (csr_era),
        .csr_badv_we    (csr_badv_we),
        .csr_badv       (csr_badv),
        .ertn_commit    (ertn_commit),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef EXCP_PERF_CNT_EN
        .perf_excp_cnt  (perf_excp_cnt),
        .perf_ertn_cnt  (perf_ertn_cnt),
`endif
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          ertn;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] era;
        bit          bwe;
        logic [31:0] badv;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] tgtq[$];
    exp_t        mon_e;
    logic [31:0] mon_t;

    always @(negedge clk) begin
        if (!reset) begin
            if (csr_excp_we || ertn_commit) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_commit", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_ertn_commit", ertn_commit, mon_e.ertn);
                    chk("sb_excp_we", csr_excp_we, !mon_e.ertn);
                    chk("sb_flush_all", flush_all, 1);
                    if (!mon_e.ertn) begin
                        chk("sb_ecode", csr_ecode, mon_e.ecode);
                        chk("sb_esub", csr_esubcode, mon_e.esub);
                        chk("sb_era", csr_era, mon_e.era);
                        chk("sb_badv_we", csr_badv_we, mon_e.bwe);
                        if (mon_e.bwe) chk("sb_badv", csr_badv, mon_e.badv);
                    end else begin
                        chk("sb_ertn_badv_we", csr_badv_we, 0);
                    end
                end
            end
            if (redirect_valid && redirect_ready) begin
                if (tgtq.size() == 0) begin
                    chk("sb_unexpected_redirect", 1, 0);
                end else begin
                    mon_t = tgtq.pop_front();
                    chk("sb_redirect_pc", redirect_pc, mon_t);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one WB retirement for a single cycle and record what the DUT
    // must commit for it (interrupt > exception > ERTN).
    task automatic drive_wb(input bit excp, input bit ertn, input bit intr,
                            input logic [5:0] ecode, input logic [8:0] esub,
                            input logic [31:0] pc, input logic [31:0] badv,
                            input bit bvld);
        exp_t e;
        wb_valid    = 1'b1;
        wb_excp     = excp;
        wb_ertn     = ertn;
        int_req     = intr;
        wb_ecode    = ecode;
        wb_esubcode = esub;
        wb_pc       = pc;
        wb_badv     = badv;
        wb_badv_vld = bvld;
        if (intr || excp || ertn) begin
            e.era  = pc;
            e.badv = badv;
            if (intr) begin
                e.ertn = 0; e.ecode = 6'h00; e.esub = 9'd0; e.bwe = 0;
                tgtq.push_back(csr_eentry);
            end else if (excp) begin
                e.ertn = 0; e.ecode = ecode; e.esub = esub; e.bwe = bvld;
                tgtq.push_back(csr_eentry);
            end else begin
                e.ertn = 1; e.ecode = 6'h00; e.esub = 9'd0; e.bwe = 0;
                tgtq.push_back(csr_era_in);
            end
            sbq.push_back(e);
        end
        next_cycle();
        wb_valid = 1'b0; wb_excp = 1'b0; wb_ertn = 1'b0; int_req = 1'b0;
        wb_badv_vld = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {global_flush, flush_all, csr_excp_we, csr_badv_we,
                            ertn_commit, redirect_valid}, 0);
        chk({tag, "_code"}, {csr_ecode, csr_esubcode}, 0);
        chk({tag, "_addr"}, {csr_era, csr_badv, redirect_pc}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        sbq.delete();
        tgtq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] held_pc;
        reset = 1'b1;
        {if_excp, id_excp, ex_excp, me_excp} = '0;
        wb_valid = 0; wb_excp = 0; wb_ertn = 0; int_req = 0;
        wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_badv = '0; wb_badv_vld = 0;
        csr_eentry = 32'h1c00_8000;
        csr_era_in = 32'h1c00_0200;
        redirect_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk_all_zero("reset");

        // Upstream exception at cycle 0, retires in WB at cycle 3.
        next_cycle();
        ex_excp = 1'b1;
        @(negedge clk); chk("t1_flush_c0", global_flush, 0);
        next_cycle();
        ex_excp = 1'b0;
        @(negedge clk); chk("t1_flush_c1", global_flush, 1);
        next_cycle();
        // Older instruction retires normally while draining.
        wb_valid = 1'b1;
        @(negedge clk);
        chk("t1_flush_c2", global_flush, 1);
        chk("t1_no_we_c2", csr_excp_we, 0);
        next_cycle();
        wb_valid = 1'b0;
        @(negedge clk); chk("t1_no_we_c3", csr_excp_we | flush_all, 0);
        // cycle 3 is the current cycle: drive the excepting retirement now
        drive_wb(1, 0, 0, 6'h0B, 9'd0, 32'h1c00_0010, 32'h0, 0);
        @(negedge clk);
        chk("t1_we_c4", csr_excp_we, 1);
        chk("t1_flush_all_c4", flush_all, 1);
        chk("t1_era_c4", csr_era, 32'h1c00_0010);
        chk("t1_rv_c4", redirect_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("t1_rv_c5", redirect_valid, 1);
        chk("t1_rpc_c5", redirect_pc, 32'h1c00_8000);
        chk("t1_pulse_gone_c5", csr_excp_we | flush_all, 0);
        next_cycle();
        @(negedge clk);
        chk("t1_flush_c6", global_flush, 0);
        chk("t1_rv_c6", redirect_valid, 0);

        // ERTN straight from IDLE.
        next_cycle();
        drive_wb(0, 1, 0, 6'h00, 9'd0, 32'h1c00_0400, 32'h0, 0);
        @(negedge clk);
        chk("t2_ertn", ertn_commit, 1);
        chk("t2_we", csr_excp_we, 0);
        chk("t2_flush", global_flush, 1);
        next_cycle();
        @(negedge clk);
        chk("t2_rpc", redirect_pc, 32'h1c00_0200);
        next_cycle();
        next_cycle();

        // Interrupt beats an ALE exception in the same cycle.
        drive_wb(1, 0, 1, 6'h09, 9'd0, 32'h1c00_0020, 32'h0000_0003, 1);
        @(negedge clk);
        chk("t3_ecode", csr_ecode, 6'h00);
        chk("t3_badv_we", csr_badv_we, 0);
        next_cycle();
        next_cycle();
        next_cycle();

        // Exception with badv (ADEF) and ERTN+excp treated as exception,
        // with the redirect held off for 4 cycles.
        drive_wb(1, 0, 0, 6'h08, 9'd3, 32'h1c00_0030, 32'h1c00_0031, 1);
        next_cycle(); next_cycle(); next_cycle();
        redirect_ready = 1'b0;
        csr_eentry = 32'h1c00_9000;
        drive_wb(1, 1, 0, 6'h0C, 9'd0, 32'h1c00_0040, 32'h0, 0);
        @(negedge clk);
        held_pc = 32'h1c00_9000;
        csr_eentry = 32'h1c00_a000;   // CSR changes must not disturb the held target
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_rv_held", redirect_valid, 1);
            chk("t4_rpc_held", redirect_pc, held_pc);
            chk("t4_flush_held", global_flush, 1);
        end
        next_cycle();
        redirect_ready = 1'b1;
        if_excp = 1'b1;               // flushed instruction, must be ignored
        @(negedge clk);
        next_cycle();
        if_excp = 1'b0;
        @(negedge clk);
        chk("t4_idle_flush", global_flush, 0);
        chk("t4_idle_rv", redirect_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("t4_flag_ignored", global_flush, 0);

        // Reset while draining.
        next_cycle();
        me_excp = 1'b1;
        next_cycle();
        me_excp = 1'b0;
        @(negedge clk); chk("t5_drain_flush", global_flush, 1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("t5_rst_drain");
        // From IDLE an upstream flag alone must raise the flush.
        next_cycle();
        id_excp = 1'b1;
        next_cycle();
        id_excp = 1'b0;
        @(negedge clk); chk("t5_idle_after_rst", global_flush, 1);
        drive_wb(1, 0, 0, 6'h0D, 9'd0, 32'h1c00_0050, 32'h0, 0);
        next_cycle(); next_cycle(); next_cycle();

        // Reset while waiting in REDIRECT.
        redirect_ready = 1'b0;
        drive_wb(1, 0, 0, 6'h0B, 9'd0, 32'h1c00_0060, 32'h0, 0);
        next_cycle(); next_cycle();
        @(negedge clk); chk("t5_in_redirect", redirect_valid, 1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        tgtq.delete();
        @(negedge clk);
        chk_all_zero("t5_rst_redirect");
        redirect_ready = 1'b1;
        next_cycle();
        @(negedge clk); chk("t5_stays_idle", redirect_valid | global_flush, 0);

`ifdef EXCP_PERF_CNT_EN
        do_reset();
        @(negedge clk);
        chk("perf_rst_excp", perf_excp_cnt, 0);
        chk("perf_rst_ertn", perf_ertn_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) drive_wb(0, 1, 0, 6'h00, 9'd0, 32'h1c00_0100, 32'h0, 0);
            else        drive_wb(1, 0, 0, 6'h0B, 9'd0, 32'h1c00_0100 + k, 32'h0, 0);
            next_cycle(); next_cycle(); next_cycle();
        end
        @(negedge clk);
        chk("perf_excp_cnt", perf_excp_cnt, 3);
        chk("perf_ertn_cnt", perf_ertn_cnt, 1);
`endif

        next_cycle();
        chk("sbq_drained", sbq.size(), 0);
        chk("tgtq_drained", tgtq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/excp_commit_ctrl.md
Name: excp_commit_ctrl

Overview:
Precise-exception sequencer for the 5-stage LoongArch pipeline (IF/ID/EX/ME/WB).
- Raises a registered global flush flag when any stage reports an exception, then waits for the excepting instruction to reach WB.
- Commits the exception or ERTN to the CSR file, flushes all stages and issues a PC redirect handshake to IF.
- Owns the complete flush/redirect lifecycle; replaces ad-hoc pending-flag logic.

Parameters:
ADDR_W, 32, PC/address width
ECODE_W, 6, CSR.ESTAT Ecode width
ESUB_W, 9, CSR.ESTAT EsubCode width

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
if_excp, id_excp, ex_excp, me_excp  in  1 each  upstream stage exception flags (valid-qualified by stage)
wb_valid  in  1  instruction retiring in WB this cycle
wb_excp  in  1  retiring instruction carries exception
wb_ertn  in  1  retiring instruction is ERTN
wb_ecode  in  ECODE_W  exception code
wb_esubcode  in  ESUB_W  exception subcode
wb_pc  in  ADDR_W  PC of retiring instruction
wb_badv  in  ADDR_W  faulting address
wb_badv_vld  in  1  wb_badv meaningful (ADEF/ALE)
int_req  in  1  pending enabled interrupt (from CSR)
csr_eentry  in  ADDR_W  exception entry
csr_era_in  in  ADDR_W  current ERA (ERTN target)
global_flush  out  1  flush/stall flag to all stages
flush_all  out  1  one-cycle pipeline kill
csr_excp_we  out  1  one-cycle CSR exception write
csr_ecode  out  ECODE_W
csr_esubcode  out  ESUB_W
csr_era  out  ADDR_W
csr_badv_we  out  1
csr_badv  out  ADDR_W
ertn_commit  out  1  one-cycle PLV/IE restore pulse
redirect_valid  out  1  redirect request to IF
redirect_pc  out  ADDR_W
redirect_ready  in  1  IF accepts redirect

Behaviour:
- All outputs registered; on reset every output 0, state IDLE, pending cleared. Reset in any state returns to IDLE next edge.
- States IDLE, DRAIN, COMMIT, REDIRECT.
- Commit event = wb_valid & (int_req | wb_excp | wb_ertn). Priority: int_req > wb_excp > wb_ertn. ERTN with wb_excp is treated as an exception. Interrupt: ecode 0x00, esub 0, ERA = wb_pc, badv_we 0.
- IDLE:
  - Commit event → COMMIT.
  - Else any of if/id/ex/me_excp → DRAIN.
- DRAIN: non-excepting WB retirements (older instructions) complete normally. Commit event → COMMIT.
- COMMIT: one cycle, unconditionally → REDIRECT.
  - Exception: csr_excp_we=1, flush_all=1, fields latched from WB; redirect_pc latched = csr_eentry.
  - ERTN: ertn_commit=1, flush_all=1, csr_excp_we=0; redirect_pc latched = csr_era_in.
- REDIRECT: redirect_valid=1; redirect_pc held stable until redirect_ready. Handshake → IDLE.
- global_flush: set the cycle after detection (upstream flag or commit event); high through DRAIN/COMMIT/REDIRECT; clears the cycle after the redirect handshake. New flags in COMMIT/REDIRECT are ignored (flushed instructions).
- Latency:
  - WB event at cycle t → COMMIT pulses at t+1.
  - redirect_valid from t+2.
  - IDLE at t+3 if redirect_ready is already high.
- int_req outside IDLE/DRAIN ignored; it persists in CSR and is taken on a later retirement.

Optional Feature:
EXCP_PERF_CNT_EN:
- Compiled in: adds outputs perf_excp_cnt[31:0] and perf_ertn_cnt[31:0]. Each increments on its COMMIT pulse, wraps at 2^32 and resets to 0.
- Compiled out: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package excp_pkg: state enum and ECODE constants INT=0x00, ADEF=0x08, ALE=0x09, SYS=0x0B, BRK=0x0C, INE=0x0D.
- One natural sub-module, excp_cause_sel: combinational priority mux producing cause/ERA/badv/target from WB inputs.

Test Plan:
- ex_excp=1 cycle 0, wb_excp (ecode 0x0B, pc 0x1c000010) cycle 3 → global_flush 1 from cycle 1; csr_excp_we+flush_all at cycle 4 with era 0x1c000010; redirect_pc=eentry at cycle 5.
- wb_valid & wb_ertn, csr_era_in=0x1c000200 → ertn_commit pulse; csr_excp_we stays 0; redirect_pc=0x1c000200.
- int_req & wb_excp (ALE, badv 0x3) same cycle → ecode 0x00, csr_badv_we=0.
- redirect_ready low for 4 cycles → redirect_valid and redirect_pc stable; global_flush stays 1; IDLE one cycle after ready.
- Reset asserted in DRAIN and in REDIRECT → all outputs 0 next cycle, state IDLE.
- Macro on: 3 exceptions + 1 ERTN committed → perf_excp_cnt=3, perf_ertn_cnt=1.
